// File: rtl/muldiv8_io_sequencer.sv
// Pin-side sequencer for the 8-bit mul/div core: strobed operand capture, start/done handshake, watchdog, byte-serial result.
// Optional accumulate-on-multiply path is built when MULDIV8_SEQ_ACCUMULATE_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for the strobe that captures operand A and op
// LOAD_B    | waiting for the strobe that captures operand B
// ISSUE     | one-cycle core_start pulse, watchdog cleared
// WAIT      | waiting for core_done, watchdog running
// RESULT_LO | low result byte on out_data
// RESULT_HI | high result byte on out_data
module muldiv8_io_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pin_data,
  input  logic [2:0]  pin_cmd,
  input  logic        pin_strobe,
  output logic [7:0]  core_a,
  output logic [7:0]  core_b,
  output logic [1:0]  core_op,
  output logic        core_start,
  input  logic        core_done,
  input  logic [15:0] core_result,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT,
    S_RESULT_LO,
    S_RESULT_HI
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev_q;
  logic                   strobe_edge;
  logic [7:0]             wd_q;
  logic [15:0]            result_q;
  logic [15:0]            capture_val;
  logic                   div_zero;
  logic                   wd_expired;

  assign strobe_edge = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
  assign div_zero    = core_op[1] && (pin_data == 8'h00);
  assign wd_expired  = (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pin_strobe};
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (strobe_edge) state_d = S_LOAD_B;
      S_LOAD_B:    if (strobe_edge) state_d = div_zero ? S_RESULT_LO : S_ISSUE;
      S_ISSUE:     state_d = S_WAIT;
      S_WAIT:      if (core_done || wd_expired) state_d = S_RESULT_LO;
      S_RESULT_LO: if (strobe_edge) state_d = S_RESULT_HI;
      S_RESULT_HI: if (strobe_edge) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_start = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    unique case (state_q)
      S_ISSUE: begin
        core_start = 1'b1;
        busy       = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      S_RESULT_LO: begin
        out_valid = 1'b1;
        out_data  = result_q[7:0];
      end
      S_RESULT_HI: begin
        out_valid = 1'b1;
        out_data  = result_q[15:8];
      end
      default: ;
    endcase
  end

`ifdef MULDIV8_SEQ_ACCUMULATE_EN
  logic        acc_en_q;
  logic [15:0] acc_q;

  // Accumulation applies to multiplies only; a div with accumulate set restarts the sum.
  assign capture_val = (acc_en_q && !core_op[1]) ? (acc_q + core_result) : core_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_en_q <= 1'b0;
      acc_q    <= 16'h0000;
    end else begin
      if (state_q == S_IDLE && strobe_edge)
        acc_en_q <= pin_cmd[2];
      if (state_q == S_WAIT && core_done && acc_en_q)
        acc_q <= core_op[1] ? 16'h0000 : capture_val;
      if (state_q == S_LOAD_B && strobe_edge && div_zero && acc_en_q)
        acc_q <= 16'h0000;
    end
  end
`else
  assign capture_val = core_result;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_a   <= 8'h00;
      core_b   <= 8'h00;
      core_op  <= 2'b00;
      err      <= 1'b0;
      result_q <= 16'h0000;
      wd_q     <= 8'h00;
    end else begin
      unique case (state_q)
        S_IDLE: if (strobe_edge) begin
          core_a  <= pin_data;
          core_op <= pin_cmd[1:0];
          err     <= 1'b0;
        end
        S_LOAD_B: if (strobe_edge) begin
          core_b <= pin_data;
          if (div_zero) begin
            result_q <= {core_a, 8'hFF};
            err      <= 1'b1;
          end
        end
        S_ISSUE: wd_q <= 8'h00;
        S_WAIT: begin
          wd_q <= wd_q + 8'd1;
          // core_done has priority over a watchdog expiry in the same cycle
          if (core_done) begin
            result_q <= capture_val;
          end else if (wd_expired) begin
            result_q <= 16'h0000;
            err      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv8_io_sequencer.sv
// Directed bench for muldiv8_io_sequencer with a behavioural core that answers core_start after a set latency.
module tb_muldiv8_io_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pin_data = 8'h00;
  logic [2:0]  pin_cmd = 3'b000;
  logic        pin_strobe = 1'b0;
  logic [7:0]  core_a, core_b, out_data;
  logic [1:0]  core_op;
  logic        core_start, out_valid, busy, err;
  logic        core_done = 1'b0;
  logic [15:0] core_result = 16'h0000;

  int errors = 0;
  int checks = 0;

  bit          model_en = 1'b1;
  int          model_lat = 4;
  logic [15:0] model_res = 16'h0000;
  int          start_cnt = 0;
  int          wait_cnt = 0;

  always #5 clk = ~clk;

  muldiv8_io_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_data   (pin_data),
    .pin_cmd    (pin_cmd),
    .pin_strobe (pin_strobe),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_op    (core_op),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .err        (err)
  );

  // Core model: done pulses model_lat cycles after the start cycle; also counts WAIT cycles.
  initial begin : core_model
    int cnt;
    cnt = -1;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (core_start) begin
        start_cnt++;
        wait_cnt = 0;
        cnt = model_en ? model_lat : -1;
      end else begin
        if (busy) wait_cnt++;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_done   = 1'b1;
            core_result = model_res;
            cnt = -1;
          end
        end
      end
    end
  end

  task automatic strobe(input logic [7:0] d, input logic [2:0] c);
    pin_data = d;
    pin_cmd = c;
    pin_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #1 pin_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [2:0] cmd, input logic [7:0] b,
                        input bit en, input int lat, input logic [15:0] res,
                        output logic [7:0] lo, output logic [7:0] hi, output logic e,
                        output int starts, output bit seen);
    int s0;
    model_en = en;
    model_lat = lat;
    model_res = res;
    s0 = start_cnt;
    strobe(a, cmd);
    strobe(b, 3'b000);
    wait_valid(100, seen);
    lo = out_data;
    e = err;
    strobe(8'h00, 3'b000);
    hi = out_data;
    strobe(8'h00, 3'b000);
    starts = start_cnt - s0;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL rst_busy_start: got %b%b want 00", busy, core_start); end
    checks++; if ({core_a, core_b, core_op, out_data, err} !== 27'd0) begin errors++; $display("FAIL rst_regs: got a=%h b=%h op=%b d=%h e=%b want all 0", core_a, core_b, core_op, out_data, err); end
  endtask

  task automatic test_unsigned_mul;
    logic [7:0] lo, hi; logic e; int st; bit seen;
    run_op(8'd13, 3'b000, 8'd11, 1'b1, 4, 16'h008F, lo, hi, e, st, seen);
    checks++; if (!seen) begin errors++; $display("FAIL mul_valid: got no out_valid want valid within bound"); end
    checks++; if (lo !== 8'h8F) begin errors++; $display("FAIL mul_lo: got %h want 8f", lo); end
    checks++; if (hi !== 8'h00) begin errors++; $display("FAIL mul_hi: got %h want 00", hi); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL mul_err: got %b want 0", e); end
    checks++; if (st !== 1) begin errors++; $display("FAIL mul_starts: got %0d want 1", st); end
    checks++; if (core_a !== 8'd13 || core_b !== 8'd11 || core_op !== 2'b00) begin errors++; $display("FAIL mul_operands: got a=%0d b=%0d op=%b want 13 11 00", core_a, core_b, core_op); end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL mul_idle: got v=%b d=%h want 0 00", out_valid, out_data); end
  endtask

  task automatic test_unsigned_div;
    logic [7:0] lo, hi; logic e; int st; bit seen;
    run_op(8'd200, 3'b010, 8'd7, 1'b1, 3, {8'd4, 8'd28}, lo, hi, e, st, seen);
    checks++; if (!seen) begin errors++; $display("FAIL div_valid: got no out_valid want valid within bound"); end
    checks++; if (lo !== 8'h1C || hi !== 8'h04) begin errors++; $display("FAIL div_bytes: got %h %h want 1c 04", lo, hi); end
    checks++; if (e !== 1'b0 || st !== 1 || core_op !== 2'b10) begin errors++; $display("FAIL div_ctrl: got e=%b starts=%0d op=%b want 0 1 10", e, st, core_op); end
  endtask

  task automatic test_div_zero;
    logic [7:0] lo, hi; logic e; int st; bit seen;
    run_op(8'h55, 3'b011, 8'h00, 1'b1, 4, 16'hDEAD, lo, hi, e, st, seen);
    checks++; if (!seen) begin errors++; $display("FAIL dz_valid: got no out_valid want valid within bound"); end
    checks++; if (lo !== 8'hFF || hi !== 8'h55) begin errors++; $display("FAIL dz_bytes: got %h %h want ff 55", lo, hi); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL dz_err: got %b want 1", e); end
    checks++; if (st !== 0) begin errors++; $display("FAIL dz_starts: got %0d want 0", st); end
  endtask

  task automatic test_timeout;
    bit seen;
    model_en = 1'b0;
    strobe(8'h21, 3'b000);
    strobe(8'h03, 3'b000);
    wait_valid(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL to_valid: got no out_valid want valid within bound"); end
    checks++; if (wait_cnt !== 32) begin errors++; $display("FAIL to_wait_cycles: got %0d want 32", wait_cnt); end
    checks++; if (out_data !== 8'h00 || err !== 1'b1) begin errors++; $display("FAIL to_result: got d=%h e=%b want 00 1", out_data, err); end
    strobe(8'h00, 3'b000);
    strobe(8'h00, 3'b000);
    // done in the final watchdog cycle, plus a strobe during WAIT that must be dropped
    model_en = 1'b1;
    model_lat = 32;
    model_res = 16'h1234;
    strobe(8'h21, 3'b000);
    strobe(8'h03, 3'b000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL late_busy: got %b want 1", busy); end
    strobe(8'h77, 3'b000);
    wait_valid(100, seen);
    checks++; if (!seen) begin errors++; $display("FAIL late_valid: got no out_valid want valid within bound"); end
    checks++; if (out_data !== 8'h34 || err !== 1'b0) begin errors++; $display("FAIL late_result: got d=%h e=%b want 34 0", out_data, err); end
    checks++; if (core_b !== 8'h03) begin errors++; $display("FAIL wait_strobe_b: got %h want 03", core_b); end
    strobe(8'h00, 3'b000);
    checks++; if (out_data !== 8'h12) begin errors++; $display("FAIL late_hi: got %h want 12", out_data); end
    strobe(8'h00, 3'b000);
  endtask

  task automatic test_reset_mid_wait;
    model_en = 1'b1;
    model_lat = 12;
    model_res = 16'hBEEF;
    strobe(8'h12, 3'b001);
    strobe(8'h34, 3'b000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || core_a !== 8'h00 || core_op !== 2'b00) begin errors++; $display("FAIL rw_cleared: got busy=%b v=%b a=%h op=%b want 0 0 00 00", busy, out_valid, core_a, core_op); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rw_late_done: got busy=%b v=%b d=%h want 0 0 00", busy, out_valid, out_data); end
  endtask

  task automatic test_accumulate;
    logic [7:0] lo, hi; logic e; int st; bit seen;
    run_op(8'd3, 3'b100, 8'd4, 1'b1, 2, 16'd12, lo, hi, e, st, seen);
    checks++; if ({hi, lo} !== 16'h000C) begin errors++; $display("FAIL acc_first: got %h%h want 000c", hi, lo); end
    run_op(8'd5, 3'b100, 8'd6, 1'b1, 2, 16'd30, lo, hi, e, st, seen);
`ifdef MULDIV8_SEQ_ACCUMULATE_EN
    checks++; if ({hi, lo} !== 16'h002A) begin errors++; $display("FAIL acc_second: got %h%h want 002a", hi, lo); end
    run_op(8'd9, 3'b110, 8'd2, 1'b1, 2, 16'h0104, lo, hi, e, st, seen);
    checks++; if ({hi, lo} !== 16'h0104) begin errors++; $display("FAIL acc_div: got %h%h want 0104", hi, lo); end
    run_op(8'd1, 3'b100, 8'd1, 1'b1, 2, 16'd1, lo, hi, e, st, seen);
    checks++; if ({hi, lo} !== 16'h0001) begin errors++; $display("FAIL acc_cleared: got %h%h want 0001", hi, lo); end
`else
    checks++; if ({hi, lo} !== 16'h001E) begin errors++; $display("FAIL acc_ignored: got %h%h want 001e", hi, lo); end
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_unsigned_mul;
    test_unsigned_div;
    test_div_zero;
    test_timeout;
    test_reset_mid_wait;
    test_accumulate;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
